// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: load funct3 codes and FSM state encoding.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WAIT_MUL = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Registered execute-to-writeback bundle plus the stall back-pressure returned upstream.
interface writeback_stage_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic [XLEN-1:0] wb_result;
  logic            wb_alu_to_reg;
  logic            wb_mem_to_reg;
  logic            wb_mul;
  logic [4:0]      wb_dest_reg_sel;
  logic [1:0]      wb_read_address;
  logic [2:0]      wb_alu_operation;
  logic            stall_read;

  modport master (
    output wb_valid, wb_result, wb_alu_to_reg, wb_mem_to_reg, wb_mul,
    output wb_dest_reg_sel, wb_read_address, wb_alu_operation,
    input  stall_read
  );

  modport slave (
    input  wb_valid, wb_result, wb_alu_to_reg, wb_mem_to_reg, wb_mul,
    input  wb_dest_reg_sel, wb_read_address, wb_alu_operation,
    output stall_read
  );
endinterface

// File: rtl/load_align.sv
// Combinational load alignment: selects byte/half/word from the memory word and extends it.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lanes [4];
  logic [15:0] halves [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = rdata[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign halves[gi] = rdata[16*gi +: 16];
  end

  assign byte_sel = lanes[offset];
  assign half_sel = halves[offset[1]];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU/load results and waits on the multi-cycle multiplier.
// Define WB_FORWARD_EN to expose the fwd_* bypass of the value about to be written.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  wb,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic [XLEN-1:0]   mul_product,
  input  logic              mul_done,
  output logic              reg_wr_en,
  output logic [4:0]        reg_wr_addr,
  output logic [XLEN-1:0]   reg_wr_data,
  output logic              mul_timeout
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);

  wb_state_t        state_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [4:0]       mul_rd_reg;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] idle_data;
  logic            idle_wr;
  logic            mul_wr;
  logic            wr_next;
  logic [4:0]      wr_addr_next;
  logic [XLEN-1:0] wr_data_next;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .offset (wb.wb_read_address),
    .funct3 (wb.wb_alu_operation),
    .data   (load_data)
  );

  assign idle_wr = (state_reg == WB_IDLE) && wb.wb_valid && !wb.wb_mul &&
                   wb.wb_alu_to_reg && (wb.wb_dest_reg_sel != 5'd0);
  assign idle_data = wb.wb_mem_to_reg ? load_data : wb.wb_result;
  assign mul_wr = (state_reg == WB_WAIT_MUL) && mul_done && (mul_rd_reg != 5'd0);

  assign wr_next      = idle_wr || mul_wr;
  assign wr_addr_next = mul_wr ? mul_rd_reg : wb.wb_dest_reg_sel;
  assign wr_data_next = mul_wr ? mul_product : idle_data;

  assign wb.stall_read = (state_reg == WB_WAIT_MUL);

`ifdef WB_FORWARD_EN
  assign fwd_valid = wr_next;
  assign fwd_addr  = wr_addr_next;
  assign fwd_data  = wr_data_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= WB_IDLE;
      tmo_cnt_reg <= '0;
      mul_rd_reg  <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      mul_timeout <= 1'b0;
    end else begin
      reg_wr_en <= wr_next;
      if (wr_next) begin
        reg_wr_addr <= wr_addr_next;
        reg_wr_data <= wr_data_next;
      end
      case (state_reg)
        WB_IDLE: begin
          if (wb.wb_valid && wb.wb_mul) begin
            state_reg   <= WB_WAIT_MUL;
            tmo_cnt_reg <= '0;
            // Destination is captured so the write does not depend on upstream holding it.
            mul_rd_reg  <= wb.wb_dest_reg_sel;
          end
        end
        WB_WAIT_MUL: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (mul_done) begin
            state_reg <= WB_IDLE;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg   <= WB_IDLE;
            mul_timeout <= 1'b1;
          end
        end
        default: state_reg <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table, multiply corner sequences, random vs model.
module tb_writeback_stage;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [XLEN-1:0]   dmem_rdata;
  logic [XLEN-1:0]   mul_product;
  logic              mul_done;
  logic              reg_wr_en;
  logic [4:0]        reg_wr_addr;
  logic [XLEN-1:0]   reg_wr_data;
  logic              mul_timeout;
`ifdef WB_FORWARD_EN
  logic              fwd_valid;
  logic [4:0]        fwd_addr;
  logic [XLEN-1:0]   fwd_data;
`endif

  writeback_stage_if #(.XLEN(XLEN)) wb_if ();

  writeback_stage #(.XLEN(XLEN), .MUL_TIMEOUT(16), .TMO_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb_if),
    .dmem_rdata  (dmem_rdata),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .mul_timeout (mul_timeout)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic alu, input logic mem,
                       input logic mul, input logic [4:0] rd, input logic [1:0] off,
                       input logic [2:0] f3, input logic [31:0] rdata);
    wb_if.wb_valid         = v;
    wb_if.wb_result        = res;
    wb_if.wb_alu_to_reg    = alu;
    wb_if.wb_mem_to_reg    = mem;
    wb_if.wb_mul           = mul;
    wb_if.wb_dest_reg_sel  = rd;
    wb_if.wb_read_address  = off;
    wb_if.wb_alu_operation = f3;
    dmem_rdata             = rdata;
  endtask

  task automatic bus_idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0);
    mul_done    = 1'b0;
    mul_product = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference load extraction by shifting and masking the word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      2: return w;
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic        alu;
    logic        mem;
    logic [4:0]  rd;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[14];

  logic        m_busy;
  int          m_waited;
  logic [4:0]  m_rd;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_tmo;
  int          stall_cnt;
  logic        saw_write;

  initial begin
    vecs[0]  = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd5,  2'd3, 3'd0, 32'h80FF_1234, 1'b1, 5'd5,  32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd6,  2'd2, 3'd5, 32'h8001_0000, 1'b1, 5'd6,  32'h0000_8001};
    vecs[2]  = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd6,  2'd2, 3'd1, 32'h8001_0000, 1'b1, 5'd6,  32'hFFFF_8001};
    vecs[3]  = '{1'b1, 32'h2A, 1'b1, 1'b0, 5'd0,  2'd0, 3'd0, 32'h1111_1111, 1'b0, 5'd0,  32'h0};
    vecs[4]  = '{1'b1, 32'h2A, 1'b1, 1'b0, 5'd3,  2'd0, 3'd0, 32'h1111_1111, 1'b1, 5'd3,  32'h0000_002A};
    vecs[5]  = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd4,  2'd1, 3'd4, 32'h80FF_1234, 1'b1, 5'd4,  32'h0000_0012};
    vecs[6]  = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd8,  2'd3, 3'd2, 32'hDEAD_BEEF, 1'b1, 5'd8,  32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h77, 1'b1, 1'b1, 5'd9,  2'd0, 3'd3, 32'hDEAD_BEEF, 1'b1, 5'd9,  32'h0};
    vecs[8]  = '{1'b0, 32'h55, 1'b1, 1'b0, 5'd10, 2'd0, 3'd0, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[9]  = '{1'b1, 32'h55, 1'b0, 1'b0, 5'd10, 2'd0, 3'd0, 32'h0,         1'b0, 5'd0,  32'h0};
    vecs[10] = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd11, 2'd0, 3'd1, 32'h80FF_1234, 1'b1, 5'd11, 32'h0000_1234};
    vecs[11] = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd12, 2'd2, 3'd0, 32'h80FF_1234, 1'b1, 5'd12, 32'hFFFF_FFFF};
    vecs[12] = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd13, 2'd0, 3'd6, 32'h80FF_1234, 1'b1, 5'd13, 32'h0};
    vecs[13] = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd14, 2'd1, 3'd5, 32'h80FF_1234, 1'b1, 5'd14, 32'h0000_1234};

    bus_idle();
    do_reset();
    check("reset_en",   {31'b0, reg_wr_en},   32'd0);
    check("reset_addr", {27'b0, reg_wr_addr}, 32'd0);
    check("reset_data", reg_wr_data,          32'd0);
    check("reset_tmo",  {31'b0, mul_timeout}, 32'd0);
    check("reset_stall", {31'b0, wb_if.stall_read}, 32'd0);

    // Table vectors: one bundle per cycle; addr/data hold when no write is expected.
    m_addr = 5'd0;
    m_data = 32'h0;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].res, vecs[i].alu, vecs[i].mem, 1'b0, vecs[i].rd,
            vecs[i].off, vecs[i].f3, vecs[i].rdata);
      tick();
      if (vecs[i].en) begin
        m_addr = vecs[i].addr;
        m_data = vecs[i].data;
      end
      $display("[TB] vec %0d rd=%0d f3=%0d en=%0b addr=%0d data=%08h", i, vecs[i].rd,
               vecs[i].f3, reg_wr_en, reg_wr_addr, reg_wr_data);
      check($sformatf("vec%0d_en", i),   {31'b0, reg_wr_en},   {31'b0, vecs[i].en});
      check($sformatf("vec%0d_addr", i), {27'b0, reg_wr_addr}, {27'b0, m_addr});
      check($sformatf("vec%0d_data", i), reg_wr_data,          m_data);
    end
    bus_idle();
    tick();
    check("pulse_single", {31'b0, reg_wr_en}, 32'd0);

    // Multiply to x7 with mul_done in the fourth stalled cycle.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_stall_c%0d", i + 1), {31'b0, wb_if.stall_read}, 32'd1);
      check($sformatf("mul_nowr_c%0d", i + 1),  {31'b0, reg_wr_en},        32'd0);
      if (i == 3) begin
        mul_done    = 1'b1;
        mul_product = 32'h0000_0C35;
      end
      tick();
    end
    mul_done = 1'b0;
    wb_if.wb_valid = 1'b0;
    $display("[TB] mul x7 en=%0b addr=%0d data=%08h", reg_wr_en, reg_wr_addr, reg_wr_data);
    check("mul_en",    {31'b0, reg_wr_en},        32'd1);
    check("mul_addr",  {27'b0, reg_wr_addr},      32'd7);
    check("mul_data",  reg_wr_data,               32'h0000_0C35);
    check("mul_stall_end", {31'b0, wb_if.stall_read}, 32'd0);
    tick();
    check("mul_en_pulse", {31'b0, reg_wr_en}, 32'd0);

    // Multiply with no mul_done: timeout after 16 stalled cycles.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 3'd0, 32'h0);
    tick();
    stall_cnt = 0;
    saw_write = 1'b0;
    while (wb_if.stall_read && stall_cnt < 40) begin
      stall_cnt++;
      tick();
      saw_write = saw_write | reg_wr_en;
      if (!wb_if.stall_read) wb_if.wb_valid = 1'b0;
    end
    wb_if.wb_valid = 1'b0;
    $display("[TB] timeout stall_cycles=%0d tmo=%0b", stall_cnt, mul_timeout);
    check("tmo_cycles", stall_cnt,                 32'd16);
    check("tmo_flag",   {31'b0, mul_timeout},      32'd1);
    check("tmo_nowr",   {31'b0, saw_write},        32'd0);
    tick();
    check("tmo_sticky", {31'b0, mul_timeout},      32'd1);
    do_reset();
    check("tmo_cleared", {31'b0, mul_timeout},     32'd0);

    // mul_done coinciding with the final timeout cycle: write wins.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd14, 2'd0, 3'd0, 32'h0);
    tick();
    for (int i = 1; i < 16; i++) tick();
    mul_done    = 1'b1;
    mul_product = 32'hCAFE_0001;
    tick();
    mul_done = 1'b0;
    wb_if.wb_valid = 1'b0;
    $display("[TB] coincide en=%0b data=%08h tmo=%0b", reg_wr_en, reg_wr_data, mul_timeout);
    check("coinc_en",   {31'b0, reg_wr_en},   32'd1);
    check("coinc_data", reg_wr_data,          32'hCAFE_0001);
    check("coinc_tmo",  {31'b0, mul_timeout}, 32'd0);

    // Reset during WAIT_MUL, then a late mul_done.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd21, 2'd0, 3'd0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wb_if.wb_valid = 1'b0;
    mul_done    = 1'b1;
    mul_product = 32'h1234_5678;
    check("rst_mid_stall", {31'b0, wb_if.stall_read}, 32'd0);
    check("rst_mid_en",    {31'b0, reg_wr_en},        32'd0);
    check("rst_mid_data",  reg_wr_data,               32'd0);
    tick();
    mul_done = 1'b0;
    $display("[TB] reset-mid-mul en=%0b stall=%0b", reg_wr_en, wb_if.stall_read);
    check("rst_late_en",    {31'b0, reg_wr_en},        32'd0);
    check("rst_late_addr",  {27'b0, reg_wr_addr},      32'd0);
    check("rst_late_stall", {31'b0, wb_if.stall_read}, 32'd0);

    // Random stimulus against a cycle-level reference model.
    bus_idle();
    do_reset();
    m_busy = 1'b0; m_waited = 0; m_rd = 5'd0; m_tmo = 1'b0;
    m_addr = 5'd0; m_data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!m_busy) begin
        drive($urandom_range(0, 4) != 0, $urandom, $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom);
      end else begin
        dmem_rdata = $urandom;
      end
      mul_done    = $urandom_range(0, 5) == 0;
      mul_product = $urandom;

      m_en = 1'b0;
      if (!m_busy) begin
        if (wb_if.wb_valid && wb_if.wb_mul) begin
          m_busy = 1'b1; m_waited = 0; m_rd = wb_if.wb_dest_reg_sel;
        end else if (wb_if.wb_valid && wb_if.wb_alu_to_reg && wb_if.wb_dest_reg_sel != 0) begin
          m_en = 1'b1;
          m_addr = wb_if.wb_dest_reg_sel;
          m_data = wb_if.wb_mem_to_reg ?
                   ref_load(dmem_rdata, int'(wb_if.wb_read_address), int'(wb_if.wb_alu_operation)) :
                   wb_if.wb_result;
        end
      end else begin
        m_waited++;
        if (mul_done) begin
          m_busy = 1'b0;
          if (m_rd != 0) begin
            m_en = 1'b1; m_addr = m_rd; m_data = mul_product;
          end
        end else if (m_waited == 16) begin
          m_busy = 1'b0;
          m_tmo = 1'b1;
        end
      end
`ifdef WB_FORWARD_EN
      #1;
      check($sformatf("rnd%0d_fwd_valid", c), {31'b0, fwd_valid}, {31'b0, m_en});
      if (m_en) begin
        check($sformatf("rnd%0d_fwd_addr", c), {27'b0, fwd_addr}, {27'b0, m_addr});
        check($sformatf("rnd%0d_fwd_data", c), fwd_data, m_data);
      end
`endif
      tick();
      $display("[TB] rnd %0d en=%0b addr=%0d data=%08h stall=%0b tmo=%0b", c, reg_wr_en,
               reg_wr_addr, reg_wr_data, wb_if.stall_read, mul_timeout);
      check($sformatf("rnd%0d_en", c),    {31'b0, reg_wr_en},        {31'b0, m_en});
      check($sformatf("rnd%0d_addr", c),  {27'b0, reg_wr_addr},      {27'b0, m_addr});
      check($sformatf("rnd%0d_data", c),  reg_wr_data,               m_data);
      check($sformatf("rnd%0d_stall", c), {31'b0, wb_if.stall_read}, {31'b0, m_busy});
      check($sformatf("rnd%0d_tmo", c),   {31'b0, mul_timeout},      {31'b0, m_tmo});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
